// File: rtl/apb_pkg.sv
// Shared definitions for the APB multi-slave requester: FSM state type and
// default width constants used as parameter defaults by the other files.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int DEF_ADDR_W          = 32;
  localparam int DEF_DATA_W          = 32;
  localparam int DEF_NUM_SLAVES      = 4;
  localparam int DEF_SLAVE_ADDR_BITS = 12;
  localparam int DEF_TIMEOUT_CYCLES  = 16;

endpackage

// File: rtl/apb_addr_decoder.sv
// Address decoder: each completer owns a 2^SLAVE_ADDR_BITS byte window.
// The window index selects one PSEL bit; an index past the last completer
// produces no select and raises dec_err instead.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int NUM_SLAVES      = DEF_NUM_SLAVES,
  parameter int SLAVE_ADDR_BITS = DEF_SLAVE_ADDR_BITS
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  dec_err
);

  logic [ADDR_W-1:0] index;

  assign index   = addr >> SLAVE_ADDR_BITS;
  assign dec_err = (index >= ADDR_W'(NUM_SLAVES));

  // One-hot select from the window index; stays all-zero on a decode error
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (index == ADDR_W'(i)) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_multi_slave_master.sv
// APB requester fanning out to NUM_SLAVES completers.
// One request at a time: IDLE -> SETUP -> ACCESS (wait states) -> RESP.
// Optional macro APB_TIMEOUT_EN bounds the ACCESS wait to TIMEOUT_CYCLES.
module apb_multi_slave_master
  import apb_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int NUM_SLAVES      = DEF_NUM_SLAVES,
  parameter int SLAVE_ADDR_BITS = DEF_SLAVE_ADDR_BITS,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int STRB_W          = DATA_W / 8
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [STRB_W-1:0]            req_strb,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [STRB_W-1:0]            PSTRB,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  apb_state_e state, next_state;

  logic [NUM_SLAVES-1:0] sel_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic                  write_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_err;
  logic                  handshake;
  logic                  pready_sel;
  logic                  pslverr_sel;
  logic [DATA_W-1:0]     prdata_sel;
  logic                  timeout_hit;

  apb_addr_decoder #(
    .ADDR_W          (ADDR_W),
    .NUM_SLAVES      (NUM_SLAVES),
    .SLAVE_ADDR_BITS (SLAVE_ADDR_BITS)
  ) u_decoder (
    .addr    (req_addr),
    .sel     (dec_sel),
    .dec_err (dec_err)
  );

  // Ready only in IDLE and never while reset is asserted
  assign req_ready = PRESETn && (state == IDLE);
  assign handshake = req_valid && req_ready;

  // Only the selected completer's handshake signals matter
  assign pready_sel  = |(PREADY & sel_q);
  assign pslverr_sel = |(PSLVERR & sel_q);

  // Read-data mux driven by the registered one-hot select
  always_comb begin
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) prdata_sel = prdata_sel | PRDATA[i*DATA_W +: DATA_W];
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Count ACCESS cycles spent waiting; cleared whenever outside ACCESS
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (state != ACCESS) begin
      wait_cnt <= '0;
    end else if (!pready_sel) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ACCESS) && !pready_sel &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic; a decode error skips the APB phases entirely
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (handshake) next_state = dec_err ? RESP : SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (pready_sel || timeout_hit) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture at handshake and response capture at the end of ACCESS
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (handshake) begin
      sel_q   <= dec_sel;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      strb_q  <= req_strb;
      write_q <= req_write;
      rdata_q <= '0;
      err_q   <= dec_err;
    end else if (state == ACCESS && pready_sel) begin
      rdata_q <= write_q ? '0 : prdata_sel;
      err_q   <= pslverr_sel;
    end else if (timeout_hit) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end
  end

  assign PSEL      = (state == SETUP || state == ACCESS) ? sel_q : '0;
  assign PENABLE   = (state == ACCESS);
  assign PWRITE    = write_q;
  assign PADDR     = addr_q;
  assign PWDATA    = write_q ? wdata_q : '0;
  assign PSTRB     = write_q ? strb_q : '0;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_multi_slave_master.sv
// Self-checking bench for apb_multi_slave_master: directed vector table,
// randomized transfers against a reference model, and hand-written
// reset / stuck-completer sequences. Honours APB_TIMEOUT_EN if defined.
module tb_apb_multi_slave_master;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        slverr;
    logic [31:0] rdata;
    logic [3:0]  exp_psel;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_acc;
  } vec_t;

  logic         PCLK = 1'b0;
  logic         PRESETn = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic [3:0]   req_strb = '0;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [3:0]   PSEL;
  logic         PENABLE;
  logic         PWRITE;
  logic [31:0]  PADDR;
  logic [31:0]  PWDATA;
  logic [3:0]   PSTRB;
  logic [127:0] PRDATA = '0;
  logic [3:0]   PREADY = '0;
  logic [3:0]   PSLVERR = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 PCLK = ~PCLK;

  apb_multi_slave_master dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference model: 4 KiB windows, 4 completers, one SETUP, waits+1 ACCESS
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic [31:0] idx;
    r = v;
    idx = v.addr >> 12;
    if (idx >= 4) begin
      r.exp_psel = 4'b0000; r.exp_err = 1'b1; r.exp_rdata = '0;
      r.exp_lat = 1; r.exp_acc = 0;
    end else begin
      r.exp_psel = 4'b0001 << idx;
`ifdef APB_TIMEOUT_EN
      if (v.waits >= 16) begin
        r.exp_err = 1'b1; r.exp_rdata = '0; r.exp_acc = 16; r.exp_lat = 18;
        return r;
      end
`endif
      r.exp_err   = v.slverr;
      r.exp_rdata = v.write ? 32'h0 : v.rdata;
      r.exp_acc   = v.waits + 1;
      r.exp_lat   = v.waits + 3;
    end
    return r;
  endfunction

  // Run one transfer; acts as the selected completer with v.waits wait states
  task automatic applyStimulus(input string tag, input vec_t v);
    int cyc = 1;
    int setups = 0;
    int accs = 0;
    int bad = 0;
    logic done = 1'b0;
    logic rdy;
    logic [3:0] mask = v.exp_psel;
    @(negedge PCLK);
    checkOutput({tag, "/req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr;
    req_wdata = v.wdata; req_strb = v.strb;
    PREADY = ~mask; PSLVERR = ~mask;
    PRDATA = {$urandom, $urandom, $urandom, $urandom};
    @(negedge PCLK);
    while (!done && cyc <= 200) begin
      if (rsp_valid) begin
        done = 1'b1;
      end else begin
        if (req_ready) bad++;
        if (PSEL != 4'b0 || PENABLE) begin
          if (PSEL !== mask || PADDR !== v.addr || PWRITE !== v.write ||
              PWDATA !== (v.write ? v.wdata : 32'h0) ||
              PSTRB !== (v.write ? v.strb : 4'h0)) bad++;
          if (PENABLE) accs++;
          else setups++;
        end
        req_valid = 1'b1; req_write = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_strb = 4'($urandom);
        rdy = PENABLE && (accs > v.waits);
        PREADY  = ~mask | (rdy ? mask : 4'b0);
        PSLVERR = ~mask | (((rdy ? v.slverr : !v.slverr)) ? mask : 4'b0);
        PRDATA  = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++)
          if (rdy && mask[i]) PRDATA[i*32 +: 32] = v.rdata;
        @(negedge PCLK);
        cyc++;
      end
    end
    req_valid = 1'b0;
    checkOutput({tag, "/rsp_seen"}, done, 1);
    checkOutput({tag, "/latency"}, cyc, v.exp_lat);
    checkOutput({tag, "/rsp_err"}, rsp_err, v.exp_err);
    checkOutput({tag, "/rsp_rdata"}, rsp_rdata, v.exp_rdata);
    checkOutput({tag, "/setup_cycles"}, setups, (mask != 0) ? 1 : 0);
    checkOutput({tag, "/access_cycles"}, accs, v.exp_acc);
    checkOutput({tag, "/bus_errors"}, bad, 0);
    PREADY = '0; PSLVERR = '0;
    @(negedge PCLK);
    checkOutput({tag, "/rsp_one_shot"}, rsp_valid, 0);
  endtask

  // Assert reset between edges, check outputs drop at once, then release
  task automatic resetSequence(input string tag);
    @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    checkOutput({tag, "/reset_apb"}, {PSEL, PENABLE, PWRITE, PSTRB, PADDR}, 0);
    checkOutput({tag, "/reset_pwdata"}, PWDATA, 0);
    checkOutput({tag, "/reset_rsp"}, {rsp_valid, rsp_err, rsp_rdata}, 0);
    checkOutput({tag, "/reset_req_ready"}, req_ready, 0);
    req_valid = 1'b0; PREADY = '0; PSLVERR = '0; PRDATA = '0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    checkOutput({tag, "/post_reset_req_ready"}, req_ready, 1);
  endtask

  vec_t tbl[9];
  vec_t v;
  int   seen;

  initial begin
    tbl[0] = '{1'b1, 32'h0000_000C, 32'h0000_000B, 4'hF, 0, 1'b0, 32'h0,
               4'b0001, 1'b0, 32'h0, 3, 1};
    tbl[1] = '{1'b0, 32'h0000_100C, 32'h0000_0055, 4'hF, 2, 1'b0, 32'hDEAD_BEEF,
               4'b0010, 1'b0, 32'hDEAD_BEEF, 5, 3};
    tbl[2] = '{1'b0, 32'h0000_4000, 32'h0, 4'h0, 0, 1'b0, 32'h1111_2222,
               4'b0000, 1'b1, 32'h0, 1, 0};
    tbl[3] = '{1'b1, 32'h0000_2010, 32'h0000_A5A5, 4'h3, 0, 1'b1, 32'h0,
               4'b0100, 1'b1, 32'h0, 3, 1};
    tbl[4] = '{1'b1, 32'h0000_2010, 32'h0000_A5A5, 4'h3, 0, 1'b0, 32'h0,
               4'b0100, 1'b0, 32'h0, 3, 1};
    tbl[5] = '{1'b0, 32'h0000_3FFC, 32'h0000_0001, 4'hF, 1, 1'b0, 32'h1234_5678,
               4'b1000, 1'b0, 32'h1234_5678, 4, 2};
    tbl[6] = '{1'b1, 32'h0000_1F00, 32'hCAFE_0000, 4'h5, 3, 1'b0, 32'h0000_0077,
               4'b0010, 1'b0, 32'h0, 6, 4};
    tbl[7] = '{1'b0, 32'hFFFF_F000, 32'h0, 4'h0, 0, 1'b0, 32'h0,
               4'b0000, 1'b1, 32'h0, 1, 0};
    tbl[8] = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, 1'b1, 32'h0000_0099,
               4'b0001, 1'b1, 32'h0000_0099, 3, 1};

    resetSequence("init");

    for (int i = 0; i < 9; i++) applyStimulus($sformatf("tbl%0d", i), tbl[i]);

    for (int i = 0; i < 40; i++) begin
      v.write  = 1'($urandom);
      v.addr   = ($urandom_range(0, 5) << 12) | ($urandom & 32'hFFF);
      v.wdata  = $urandom;
      v.strb   = 4'($urandom);
      v.waits  = $urandom_range(0, 6);
      v.slverr = 1'($urandom);
      v.rdata  = $urandom;
      applyStimulus($sformatf("rnd%0d", i), model(v));
    end

    // Completer 3 never answers
`ifdef APB_TIMEOUT_EN
    v = '{1'b0, 32'h0000_3000, 32'h0, 4'h0, 1000, 1'b0, 32'h0BAD_0BAD,
          4'b0, 1'b0, 32'h0, 0, 0};
    applyStimulus("timeout", model(v));
`else
    @(negedge PCLK);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_3000;
    req_wdata = '0; req_strb = '0;
    PREADY = 4'b0111; PSLVERR = 4'b1111;
    @(negedge PCLK);
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) seen++;
      @(negedge PCLK);
    end
    checkOutput("hang/no_rsp", seen, 0);
    checkOutput("hang/penable", PENABLE, 1);
    checkOutput("hang/psel", PSEL, 4'b1000);
    resetSequence("hang");
`endif

    // Reset in the middle of an ACCESS phase
    @(negedge PCLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_1004;
    req_wdata = 32'h5A5A_5A5A; req_strb = 4'hF;
    PREADY = 4'b0000;
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    checkOutput("midreset/in_access", {PSEL, PENABLE}, {4'b0010, 1'b1});
    resetSequence("midreset");
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) seen++;
      @(negedge PCLK);
    end
    checkOutput("midreset/no_rsp", seen, 0);
    applyStimulus("post_reset_write", tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_multi_slave_master.md
APB_MULTI_SLAVE_MASTER -- requirements
Module: apb_multi_slave_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; multiple of 8. STRB_W = DATA_W/8.
REQ-003 SHALL have parameter NUM_SLAVES, default 4, number of APB completers.
REQ-004 SHALL have parameter SLAVE_ADDR_BITS, default 12, per-slave window size (2^SLAVE_ADDR_BITS bytes).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: PCLK  in  1  clock; PRESETn  in  1  async active-low reset.
REQ-007 req_valid  in  1  request present; req_ready  out  1  request accepted this cycle.
REQ-008 req_write  in  1  1=write, 0=read; req_addr  in  ADDR_W; req_wdata  in  DATA_W; req_strb  in  STRB_W.
REQ-009 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  DATA_W; rsp_err  out  1.
REQ-010 PSEL  out  NUM_SLAVES  one-hot select; PENABLE  out  1; PWRITE  out  1; PADDR  out  ADDR_W; PWDATA  out  DATA_W; PSTRB  out  STRB_W.
REQ-011 PRDATA  in  NUM_SLAVES*DATA_W  flattened, slave i at [i*DATA_W +: DATA_W]; PREADY  in  NUM_SLAVES; PSLVERR  in  NUM_SLAVES.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-013 req_ready SHALL be 1 only in IDLE; handshake = req_valid && req_ready; requests in other states are ignored, not queued.
REQ-014 On handshake SHALL register addr/wdata/strb/write, decode index = req_addr >> SLAVE_ADDR_BITS, go to SETUP.
REQ-015 Index >= NUM_SLAVES (decode error): SHALL skip APB, go to RESP with rsp_err=1, rsp_rdata=0, PSEL all 0.
REQ-016 SETUP: exactly one cycle, PSEL[index]=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB valid; next ACCESS.
REQ-017 ACCESS: PENABLE=1, all APB outputs held stable; stay until PREADY[index]=1.
REQ-018 PSTRB SHALL equal registered req_strb on writes and 0 on reads; PWDATA SHALL be 0 on reads.
REQ-019 On PREADY[index]=1 in ACCESS SHALL capture PRDATA slice (reads; 0 for writes) and PSLVERR[index], drop PSEL/PENABLE, go to RESP.
REQ-020 RESP: rsp_valid=1 for exactly one cycle, then IDLE; minimum latency handshake-to-rsp_valid = 3 cycles with zero wait states.
REQ-021 PREADY/PSLVERR/PRDATA of non-selected slaves SHALL be ignored; PSLVERR sampled only with PREADY in ACCESS.

Reset
REQ-022 PRESETn low SHALL asynchronously force IDLE and all outputs to 0 except req_ready (1 after reset release, 0 while PRESETn low).
REQ-023 Reset mid-transfer SHALL abandon it with no rsp_valid; first post-reset handshake proceeds normally.

Configuration
REQ-024 Macro APB_TIMEOUT_EN defined: ACCESS cycle counter; if PREADY[index] stays 0 for TIMEOUT_CYCLES ACCESS cycles, SHALL end transfer, go to RESP with rsp_err=1, rsp_rdata=0.
REQ-025 Macro undefined: no counter; ACCESS waits indefinitely.

Structure
REQ-026 Package apb_pkg SHALL hold the FSM state typedef and default width constants.
REQ-027 Sub-module apb_addr_decoder SHALL map address to one-hot select plus decode-error flag.

Verification
REQ-028 Write addr 0x0C, data 0x0B, strb 0xF, PREADY[0]=1 -> PSEL=0001 one SETUP + one ACCESS cycle, PSTRB=0xF, rsp_valid 3 cycles after handshake, rsp_err=0.
REQ-029 Read addr 0x100C, slave1 PRDATA=0xDEADBEEF, PREADY[1] low 2 cycles -> PSEL=0010, PSTRB=0, ACCESS 3 cycles, rsp_rdata=0xDEADBEEF.
REQ-030 Read addr 0x4000 (index 4) -> no PSEL, rsp_valid with rsp_err=1, rsp_rdata=0.
REQ-031 Write to slave 2 with PSLVERR[2]=1 at PREADY, PSLVERR[0]=1 throughout -> rsp_err=1 only from slave 2; repeat with PSLVERR[2]=0 -> rsp_err=0.
REQ-032 APB_TIMEOUT_EN, PREADY[3] stuck 0 -> exit after 16 ACCESS cycles, rsp_err=1; without macro, still in ACCESS at cycle 100.
REQ-033 PRESETn low during ACCESS -> all outputs 0 immediately, no rsp_valid; next write after release completes normally.
